data_memory_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the 16-bit data memory (1600 words; registered read on rising edge, write on falling edge). Port 0 serves the processor load/store stage, port 1 a secondary master (loader/debug/DMA). The block grants one request at a time, drives the memory's MemRead/MemWrite/address/writeData pins for exactly one cycle per access, and returns read data to the granted port.

---
 rtl/data_memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin 2-port access sequencer for the data memory; define DMEM_BOUNDS_CHECK_EN to reject addr >= MEM_DEPTH.
// Latency: gnt+strobe in the cycle after req is sampled, rdata/rvalid 2 cycles after gnt; req held until gnt, ignored while busy.
module data_memory_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 1600
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] writeData_o,
  input  logic [DATA_W-1:0] dataRead_i
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q;
  logic              port_q;
  logic              last_q;
  logic              gnt0_q, gnt1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              err0_q, err1_q;
  logic              mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              pick1_d;
  logic              we_d;
  logic              oob_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick1_d = req1_i && (!req0_i || !last_q);
    we_d    = pick1_d ? we1_i    : we0_i;
    addr_d  = pick1_d ? addr1_i  : addr0_i;
    wdata_d = pick1_d ? wdata1_i : wdata0_i;
    oob_d   = CheckEn && (32'(addr_d) >= 32'(MEM_DEPTH));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            state_q <= BUSY;
            port_q  <= pick1_d;
            last_q  <= pick1_d;
            gnt0_q  <= !pick1_d;
            gnt1_q  <= pick1_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (oob_d) begin
              err0_q <= !pick1_d;
              err1_q <= pick1_d;
            end else begin
              mem_rd_q <= !we_d;
              mem_wr_q <= we_d;
            end
          end
        end
        // Only an in-range read needs the response cycle.
        BUSY: state_q <= mem_rd_q ? RESP : IDLE;
        RESP: begin
          state_q <= IDLE;
          if (port_q) begin
            rdata1_q  <= dataRead_i;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= dataRead_i;
            rvalid0_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign MemRead_o   = mem_rd_q;
  assign MemWrite_o  = mem_wr_q;
  assign address_o   = addr_q;
  assign writeData_o = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random two-port traffic,
// checked every cycle against a cycle-indexed transaction model and a memory image.
module tb_data_memory_arbiter;
  localparam int DEPTH = 1600;
  localparam int NCYC  = 8192;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rq  = 2'b00;
  logic [1:0]  wr  = 2'b00;
  logic [15:0] ad [2];
  logic [15:0] wd [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, MemRead, MemWrite;
  logic [15:0] rdata0, rdata1, address, writeData;
  logic [15:0] dataRead = 16'h0;
  logic [1:0]  gnt_v;

  always #5 clk = ~clk;
  assign gnt_v = {gnt1, gnt0};

  data_memory_arbiter dut (
    .clock_i(clk), .reset_i(rst),
    .req0_i(rq[0]), .req1_i(rq[1]), .we0_i(wr[0]), .we1_i(wr[1]),
    .addr0_i(ad[0]), .addr1_i(ad[1]), .wdata0_i(wd[0]), .wdata1_i(wd[1]),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .err0_o(err0), .err1_o(err1),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .address_o(address),
    .writeData_o(writeData), .dataRead_i(dataRead)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 7 + 32'h1000);
  endfunction

  // Memory: write on falling edge, registered read on rising edge.
  logic [15:0] mem [DEPTH];
  bit          mem_init = 1'b0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
      mem_init = 1'b1;
    end
    if (MemWrite === 1'b1 && int'(address) < DEPTH) mem[address[10:0]] = writeData;
  end
  always @(posedge clk) begin
    if (MemRead === 1'b1) dataRead <= (int'(address) < DEPTH) ? mem[address[10:0]] : 16'h0;
  end

  // Model: expected outputs per cycle number, filled in when a grant is predicted.
  int          cyc = 0;
  bit          e_gnt [2][NCYC];
  bit          e_rv  [2][NCYC];
  bit          e_err [2][NCYC];
  bit          e_mr  [NCYC];
  bit          e_mw  [NCYC];
  logic [15:0] e_rdv [2][NCYC];
  logic [15:0] gold  [DEPTH];
  bit          gold_init = 1'b0;
  int          m_free = 0;
  int          m_last = 1;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_wd = 16'h0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};
  bit          m_known [2] = '{1'b1, 1'b1};

  always @(posedge clk) begin
    int          w;
    logic [15:0] a;
    cyc = cyc + 1;
    if (!gold_init) begin
      for (int i = 0; i < DEPTH; i++) gold[i] = init_val(i);
      gold_init = 1'b1;
    end
    if (rst) begin
      for (int k = cyc; k < cyc + 4; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (e_rv[p][k]) m_known[p] = 1'b0;
          e_rv[p][k] = 1'b0; e_gnt[p][k] = 1'b0; e_err[p][k] = 1'b0;
        end
        e_mr[k] = 1'b0; e_mw[k] = 1'b0;
      end
      m_last = 1; m_free = cyc + 1; m_addr = 16'h0; m_wd = 16'h0;
      m_rd[0] = 16'h0; m_rd[1] = 16'h0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (e_rv[p][cyc]) begin m_rd[p] = e_rdv[p][cyc]; m_known[p] = 1'b1; end
      end
      if (cyc >= m_free && rq != 2'b00) begin
        if (rq == 2'b11) w = 1 - m_last;
        else w = rq[1] ? 1 : 0;
        m_last = w;
        a = ad[w]; m_addr = a; m_wd = wd[w];
        e_gnt[w][cyc] = 1'b1;
        if (CHECK && int'(a) >= DEPTH) begin
          e_err[w][cyc] = 1'b1; m_free = cyc + 2;
        end else if (wr[w]) begin
          e_mw[cyc] = 1'b1;
          if (int'(a) < DEPTH) gold[a[10:0]] = wd[w];
          m_free = cyc + 2;
        end else begin
          e_mr[cyc] = 1'b1;
          e_rv[w][cyc + 2] = 1'b1;
          e_rdv[w][cyc + 2] = (int'(a) < DEPTH) ? gold[a[10:0]] : 16'h0;
          m_free = cyc + 3;
        end
      end
    end
  end

  int  vectors = 0;
  int  miscompares = 0;
  int  wt [2] = '{0, 0};
  int  lit_id = 0;
  int  cnt_rv0 = 0, cnt_rv1 = 0, cnt_err1 = 0, cnt_mr = 0;
  int  b_rv0 = 0, b_rv1 = 0, b_err1 = 0, b_mr = 0, b_g = 0;
  bit  glog [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ord;
    if (cyc > 0) begin
      if (gnt0 === 1'b1) glog.push_back(1'b0);
      if (gnt1 === 1'b1) glog.push_back(1'b1);
      if (rvalid0 === 1'b1) cnt_rv0++;
      if (rvalid1 === 1'b1) cnt_rv1++;
      if (err1 === 1'b1) cnt_err1++;
      if (MemRead === 1'b1) cnt_mr++;
      chk("gnt0", 32'(gnt0), 32'(e_gnt[0][cyc]));
      chk("gnt1", 32'(gnt1), 32'(e_gnt[1][cyc]));
      chk("rvalid0", 32'(rvalid0), 32'(e_rv[0][cyc]));
      chk("rvalid1", 32'(rvalid1), 32'(e_rv[1][cyc]));
      chk("err0", 32'(err0), 32'(e_err[0][cyc]));
      chk("err1", 32'(err1), 32'(e_err[1][cyc]));
      chk("MemRead", 32'(MemRead), 32'(e_mr[cyc]));
      chk("MemWrite", 32'(MemWrite), 32'(e_mw[cyc]));
      chk("address", 32'(address), 32'(m_addr));
      chk("writeData", 32'(writeData), 32'(m_wd));
      if (m_known[0]) chk("rdata0", 32'(rdata0), 32'(m_rd[0]));
      if (m_known[1]) chk("rdata1", 32'(rdata1), 32'(m_rd[1]));
      chk("req0_wait_bound", 32'(wt[0] > 20), 32'd0);
      chk("req1_wait_bound", 32'(wt[1] > 20), 32'd0);
      case (lit_id)
        1: begin
          chk("wr_strobe", 32'(MemWrite), 32'd1);
          chk("wr_addr", 32'(address), 32'h0010);
          chk("wr_data", 32'(writeData), 32'hBEEF);
        end
        2: chk("mem_0010", 32'(mem[16]), 32'hBEEF);
        3: begin
          chk("rd_strobe_on", 32'(MemRead), 32'd1);
          chk("rd_gnt0", 32'(gnt0), 32'd1);
        end
        4: chk("rd_strobe_off", 32'(MemRead), 32'd0);
        5: begin
          chk("rd_rvalid0", 32'(rvalid0), 32'd1);
          chk("rd_rdata0", 32'(rdata0), 32'hBEEF);
        end
        6: begin
          chk("oob_err1", 32'(cnt_err1 - b_err1), CHECK ? 32'd1 : 32'd0);
          chk("oob_memread", 32'(cnt_mr - b_mr), CHECK ? 32'd0 : 32'd1);
          chk("oob_rvalid1", 32'(cnt_rv1 - b_rv1), CHECK ? 32'd0 : 32'd1);
        end
        7: begin
          chk("tie_grants", 32'(glog.size() - b_g >= 4), 32'd1);
          if (glog.size() >= b_g + 4) ord = {glog[b_g], glog[b_g+1], glog[b_g+2], glog[b_g+3]};
          else ord = 4'b1111;
          chk("tie_order", 32'(ord), 32'b0101);
          chk("tie_rdata0", 32'(rdata0), 32'h1007);
          chk("tie_rdata1", 32'(rdata1), 32'h100E);
        end
        8: begin
          chk("rst_memread", 32'(MemRead), 32'd0);
          chk("rst_memwrite", 32'(MemWrite), 32'd0);
          chk("rst_gnt0", 32'(gnt0), 32'd0);
        end
        9: chk("rst_no_rvalid0", 32'(cnt_rv0 - b_rv0), 32'd0);
        10: chk("rst_write_landed", 32'(mem[32]), 32'h1234);
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic lit(input int id);
    lit_id = id;
    tick();
    lit_id = 0;
  endtask

  // Holds the command until granted; returns #1 after the grant edge (inside BUSY).
  task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    rq[p] = 1'b1; wr[p] = w; ad[p] = a; wd[p] = d; wt[p] = 0;
    forever begin
      tick();
      if (gnt_v[p] === 1'b1 || wt[p] > 21) break;
      wt[p]++;
    end
    rq[p] = 1'b0; wt[p] = 0;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'($urandom_range(1600, 1700));
    if (r == 1) return 16'hFFFF;
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin
    ad[0] = 16'h0; ad[1] = 16'h0; wd[0] = 16'h0; wd[1] = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    lit(1);
    lit(2);
    repeat (2) tick();

    issue(0, 1'b0, 16'h0010, 16'h0000);
    lit(3);
    lit(4);
    lit(5);
    tick();

    b_err1 = cnt_err1; b_mr = cnt_mr; b_rv1 = cnt_rv1;
    issue(1, 1'b0, 16'h0640, 16'h0000);
    repeat (3) tick();
    lit(6);
    tick();

    b_g = glog.size();
    wr = 2'b00; ad[0] = 16'h0001; ad[1] = 16'h0002; rq = 2'b11;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (glog.size() >= b_g + 4) break;
    end
    rq = 2'b00;
    repeat (3) tick();
    lit(7);

    b_rv0 = cnt_rv0;
    issue(0, 1'b0, 16'h0005, 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit(8);
    repeat (2) tick();
    lit(9);

    issue(1, 1'b1, 16'h0020, 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit(10);
    tick();

    for (int k = 0; k < 1500; k++) begin
      tick();
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (rq[p]) begin
          if (gnt_v[p] === 1'b1 || wt[p] > 21) begin rq[p] = 1'b0; wt[p] = 0; end
          else wt[p]++;
        end
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1'b1;
          wr[p] = 1'($urandom_range(0, 1));
          ad[p] = rand_addr();
          wd[p] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; rq = 2'b00; wt[0] = 0; wt[1] = 0;
      end
    end
    rq = 2'b00; rst = 1'b0;
    repeat (6) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
